// File: rtl/adder_share_ctrl.sv
// adder_share_ctrl
//   Arbitrates two requesters onto one shared ripple-carry adder. The
//   granted operation is latched into operand registers that drive the
//   adder directly. Those inputs are held for SETTLE_CYCLES clocks so the
//   carry can ripple. The sum and NZCO flags are then captured into a
//   response register that has a valid/ready handshake.
//
// Ports
//   clk, rst_n                 rising-edge clock, synchronous active-low reset
//   reqN_valid/ready           per-requester handshake (ready is combinational)
//   reqN_a, reqN_b, reqN_sub   operands, sub=1 selects A-B
//   add_a, add_b, add_cin      registered drive into the shared adder
//   add_s, add_cout            adder result
//   resp_valid/ready           response handshake
//   resp_id, resp_sum          owner of the result, captured sum
//   resp_flags                 {N,Z,C,O}
module adder_share_ctrl #(
  parameter int WIDTH         = 32,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sub,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sub,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_s,
  input  logic             add_cout,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_sum,
  output logic [3:0]       resp_flags
);

  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_e;

  localparam int              CNT_W    = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_e           state_q, state_d;
  logic             prio_q, prio_d;       // 1 = requester 1 wins a tie
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;             // b already inverted for sub
  logic             cin_q, cin_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             resp_valid_q, resp_valid_d;
  logic             resp_id_q, resp_id_d;
  logic [WIDTH-1:0] resp_sum_q, resp_sum_d;
  logic [3:0]       resp_flags_q, resp_flags_d;

  logic             want0, want1;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic             sel_sub;
  logic             flag_n, flag_z, flag_c, flag_o;

  // Grant candidates. Exactly one of these can be high: a lone requester
  // always wins, and a tie goes to the requester named by the pointer.
  assign want0 = req0_valid && (!req1_valid || !prio_q);
  assign want1 = req1_valid && (!req0_valid ||  prio_q);

  assign sel_a   = want1 ? req1_a   : req0_a;
  assign sel_b   = want1 ? req1_b   : req0_b;
  assign sel_sub = want1 ? req1_sub : req0_sub;

  // Flags come from the live adder output and the held operands. Because
  // b_q is already inverted for sub, one overflow rule covers add and sub.
  assign flag_n = add_s[WIDTH-1];
  assign flag_z = (add_s == '0);
  assign flag_c = add_cout;
  assign flag_o = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_s[WIDTH-1] != a_q[WIDTH-1]);

  always_comb begin
    state_d      = state_q;
    prio_d       = prio_q;
    a_d          = a_q;
    b_d          = b_q;
    cin_d        = cin_q;
    cnt_d        = cnt_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_sum_d   = resp_sum_q;
    resp_flags_d = resp_flags_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;

    unique case (state_q)
      IDLE: begin
        req0_ready = want0;
        req1_ready = want1;
        if (want0 || want1) begin
          a_d       = sel_a;
          b_d       = sel_sub ? ~sel_b : sel_b;
          cin_d     = sel_sub;
          resp_id_d = want1;
          // The requester just served drops to low priority.
          prio_d    = ~want1;
          cnt_d     = '0;
          state_d   = SETTLE;
        end
      end

      SETTLE: begin
        if (cnt_q == CNT_LAST) begin
          resp_sum_d   = add_s;
          resp_flags_d = {flag_n, flag_z, flag_c, flag_o};
          resp_valid_d = 1'b1;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      prio_q       <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      cin_q        <= 1'b0;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_sum_q   <= '0;
      resp_flags_q <= '0;
    end else begin
      state_q      <= state_d;
      prio_q       <= prio_d;
      a_q          <= a_d;
      b_q          <= b_d;
      cin_q        <= cin_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_sum_q   <= resp_sum_d;
      resp_flags_q <= resp_flags_d;
    end
  end

  assign add_a      = a_q;
  assign add_b      = b_q;
  assign add_cin    = cin_q;
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_sum   = resp_sum_q;
  assign resp_flags = resp_flags_q;

endmodule
